dmem_rmw_ctrl: RTL and testbench

//  Data-memory access controller in the MEM stage, between the EX/MEM pipeline register and the synchronous data RAM.

---
 rtl/dmem_rmw_ctrl_pkg.sv | 30 +++
 rtl/dmem_lane_align.sv | 48 ++++
 rtl/dmem_rmw_ctrl.sv | 152 +++++++++++++++
 tb/tb_dmem_rmw_ctrl.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_rmw_ctrl_pkg.sv
// Shared constants and types for the data-memory RMW controller.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package dmem_rmw_ctrl_pkg;

  // Access size encodings carried on req_mask; 2'b11 behaves as a word.
  localparam logic [1:0] MASK_B = 2'b00;
  localparam logic [1:0] MASK_H = 2'b01;
  localparam logic [1:0] MASK_W = 2'b10;

  // Controller FSM encodings.
  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_RMW_RD = 2'b01;
  localparam logic [1:0] ST_RMW_WR = 2'b10;

  // Request fields captured in IDLE and consumed one cycle later, either by
  // the load extract path or by the RMW merge.
  typedef struct packed {
    logic [1:0]  mask;
    logic [1:0]  lane;
    logic        is_unsigned;
    logic [31:0] wdata;
  } pend_t;

  // Word and the reserved 2'b11 encoding both select a full-word access.
  function automatic logic is_word(input logic [1:0] mask);
    return mask[1];
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte/half lane alignment: store merge (MERGE=1) or load extract (MERGE=0).
// Latency: combinational.
// Backpressure: none.
//
// Ports:
//   word_in     RAM word (old word for merge, read data for extract)
//   wdata       right-justified store data (merge only)
//   mask        access size, lane  byte offset inside the word
//   is_unsigned zero-extend on extract
//   result      merged word or aligned/extended load value
module dmem_lane_align
  import dmem_rmw_ctrl_pkg::*;
#(
  parameter bit MERGE = 1'b0
) (
  input  logic [31:0] word_in,
  input  logic [31:0] wdata,
  input  logic [1:0]  mask,
  input  logic [1:0]  lane,
  input  logic        is_unsigned,
  output logic [31:0] result
);

  logic [31:0] merged;
  logic [31:0] extracted;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    merged    = wdata;
    extracted = word_in;
    byte_sel  = word_in[{lane, 3'b000} +: 8];
    // Half lane comes from addr[1] only; addr[0] never shifts a half.
    half_sel  = word_in[{lane[1], 4'b0000} +: 16];
    if (!is_word(mask)) begin
      merged = word_in;
      if (mask == MASK_B) begin
        merged[{lane, 3'b000} +: 8] = wdata[7:0];
        extracted = {{24{byte_sel[7] & ~is_unsigned}}, byte_sel};
      end else begin
        merged[{lane[1], 4'b0000} +: 16] = wdata[15:0];
        extracted = {{16{half_sel[15] & ~is_unsigned}}, half_sel};
      end
    end
    result = MERGE ? merged : extracted;
  end

endmodule

// File: rtl/dmem_rmw_ctrl.sv
// MEM-stage data RAM controller: direct word stores/loads, 2-cycle RMW for sb/sh.
// Latency: stores write same cycle (sub-word: write in next cycle); loads valid 1 cycle later.
// Backpressure: req_ready low in RMW_RD/RMW_WR; need_stall high on sub-word store issue.
//
// Ports: clk/rst (sync, active-high); req_* from EX/MEM; ram_* to synchronous
// data RAM (rdata valid the cycle after address); ld_valid/ld_data to writeback;
// misalign flags bad alignment when built with DMEM_MISALIGN_EN (else tied 0).
module dmem_rmw_ctrl
  import dmem_rmw_ctrl_pkg::*;
#(
  parameter int RAM_AW = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              req_wen,
  input  logic [1:0]        req_mask,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              req_ready,
  output logic              need_stall,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_wen,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic              ld_valid,
  output logic [31:0]       ld_data,
  output logic              misalign
);

  logic [1:0]        state_q, state_d;
  logic [RAM_AW-1:0] addr_q, addr_d;
  pend_t             pend_q, pend_d;
  logic              ld_valid_q, ld_valid_d;
  logic              ld_zero_q, ld_zero_d;

  logic        accept;
  logic        misalign_c;
  logic [31:0] merged_word;
  logic [31:0] load_word;
  logic        unused_addr_hi;

  assign unused_addr_hi = ^req_addr[31:RAM_AW+2];

  // Requests arriving outside IDLE, or during reset, are dropped.
  assign accept    = req & (state_q == ST_IDLE) & ~rst;
  assign req_ready = (state_q == ST_IDLE);

`ifdef DMEM_MISALIGN_EN
  assign misalign_c = accept & (((req_mask == MASK_H) & req_addr[0]) |
                                (is_word(req_mask) & (req_addr[1:0] != 2'b00)));
`else
  assign misalign_c = 1'b0;
`endif
  assign misalign = misalign_c;

  dmem_lane_align #(.MERGE(1'b1)) u_merge (
    .word_in     (ram_rdata),
    .wdata       (pend_q.wdata),
    .mask        (pend_q.mask),
    .lane        (pend_q.lane),
    .is_unsigned (1'b0),
    .result      (merged_word)
  );

  dmem_lane_align #(.MERGE(1'b0)) u_extract (
    .word_in     (ram_rdata),
    .wdata       (32'h0),
    .mask        (pend_q.mask),
    .lane        (pend_q.lane),
    .is_unsigned (pend_q.is_unsigned),
    .result      (load_word)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    pend_d     = pend_q;
    ld_valid_d = 1'b0;
    ld_zero_d  = 1'b0;
    ram_addr   = '0;
    ram_wen    = 1'b0;
    ram_wdata  = '0;
    need_stall = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          addr_d             = req_addr[RAM_AW+1:2];
          pend_d.mask        = req_mask;
          pend_d.lane        = req_addr[1:0];
          pend_d.is_unsigned = req_unsigned;
          pend_d.wdata       = req_wdata;
          ram_addr           = req_addr[RAM_AW+1:2];
          if (!req_wen) begin
            ld_valid_d = 1'b1;
            ld_zero_d  = misalign_c;
          end else if (!misalign_c) begin
            if (is_word(req_mask)) begin
              ram_wen   = 1'b1;
              ram_wdata = req_wdata;
            end else begin
              // Sub-word store: this cycle is the read half of the RMW.
              need_stall = 1'b1;
              state_d    = ST_RMW_RD;
            end
          end
        end
      end
      ST_RMW_RD: begin
        ram_addr  = addr_q;
        ram_wen   = 1'b1;
        ram_wdata = merged_word;
        state_d   = ST_RMW_WR;
      end
      ST_RMW_WR: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Reset aborts an in-flight RMW before its write reaches the RAM.
    if (rst) begin
      ram_addr   = '0;
      ram_wen    = 1'b0;
      ram_wdata  = '0;
      need_stall = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      pend_q     <= '0;
      ld_valid_q <= 1'b0;
      ld_zero_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      pend_q     <= pend_d;
      ld_valid_q <= ld_valid_d;
      ld_zero_q  <= ld_zero_d;
    end
  end

  assign ld_valid = ld_valid_q;
  // Misaligned loads still pulse ld_valid but return zero.
  assign ld_data  = (ld_valid_q & ~ld_zero_q) ? load_word : 32'h0;

endmodule

// File: tb/tb_dmem_rmw_ctrl.sv
// Self-checking bench for dmem_rmw_ctrl with a byte-addressed reference memory.
// Latency: n/a.
// Backpressure: n/a.
module tb_dmem_rmw_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        req_wen;
  logic [1:0]  req_mask;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        need_stall;
  logic [9:0]  ram_addr;
  logic        ram_wen;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        ld_valid;
  logic [31:0] ld_data;
  logic        misalign;

  always #5 clk = ~clk;

  dmem_rmw_ctrl #(.RAM_AW(10)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .req_wen      (req_wen),
    .req_mask     (req_mask),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_ready    (req_ready),
    .need_stall   (need_stall),
    .ram_addr     (ram_addr),
    .ram_wen      (ram_wen),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata),
    .ld_valid     (ld_valid),
    .ld_data      (ld_data),
    .misalign     (misalign)
  );

  // Synchronous RAM, read-before-write.
  logic [31:0] mem [0:1023];
  always @(posedge clk) begin
    if (ram_wen) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  // Reference model: plain byte array, little-endian.
  logic [7:0] ref_b [0:4095];

  int          vectors = 0;
  int          errors  = 0;
  bit          exp_ld_vld = 1'b0;
  logic [31:0] exp_ld_dat = '0;
  int          phase = 0;       // 0 accepting, 1 merge-write cycle, 2 bubble
  logic [31:0] pend_a, pend_d;
  logic [1:0]  pend_m;

  function automatic logic [31:0] ref_word(input logic [11:0] a);
    logic [11:0] b;
    b = {a[11:2], 2'b00};
    return {ref_b[b + 12'd3], ref_b[b + 12'd2], ref_b[b + 12'd1], ref_b[b]};
  endfunction

  function automatic logic [31:0] ref_load(input logic [11:0] a, input logic [1:0] m, input logic u);
    logic [7:0]  v;
    logic [15:0] h;
    logic [11:0] b;
    b = {a[11:1], 1'b0};
    v = ref_b[a];
    h = {ref_b[b + 12'd1], ref_b[b]};
    if (m == 2'b00) return u ? {24'h0, v} : {{24{v[7]}}, v};
    if (m == 2'b01) return u ? {16'h0, h} : {{16{h[15]}}, h};
    return ref_word(a);
  endfunction

  task automatic ref_store(input logic [11:0] a, input logic [1:0] m, input logic [31:0] d);
    logic [11:0] b;
    if (m == 2'b00) begin
      ref_b[a] = d[7:0];
    end else if (m == 2'b01) begin
      b = {a[11:1], 1'b0};
      ref_b[b] = d[7:0];
      ref_b[b + 12'd1] = d[15:8];
    end else begin
      b = {a[11:2], 2'b00};
      for (int k = 0; k < 4; k++) ref_b[b + 12'(k)] = d[8*k +: 8];
    end
  endtask

  function automatic logic model_mis(input logic [1:0] m, input logic [31:0] a);
`ifdef DMEM_MISALIGN_EN
    return ((m == 2'b01) && a[0]) || (m[1] && (a[1:0] != 2'b00));
`else
    return 1'b0;
`endif
  endfunction

  // One clock cycle: drive inputs, check outputs against the model.
  task automatic step(input logic r, input logic w, input logic [1:0] m, input logic u,
                      input logic [31:0] a, input logic [31:0] d);
    logic        mis;
    logic [31:0] ew;
    @(negedge clk);
    rst = 1'b0; req = r; req_wen = w; req_mask = m; req_unsigned = u; req_addr = a; req_wdata = d;
    #1;
    vectors++;
    if (ld_valid !== exp_ld_vld) begin
      errors++; $display("FAIL ld_valid: got %b expected %b", ld_valid, exp_ld_vld);
    end
    if (exp_ld_vld) begin
      vectors++;
      if (ld_data !== exp_ld_dat) begin
        errors++; $display("FAIL ld_data: got %h expected %h", ld_data, exp_ld_dat);
      end
    end
    exp_ld_vld = 1'b0;
    mis = (phase == 0) && r && model_mis(m, a);
    vectors++;
    if (misalign !== mis) begin
      errors++; $display("FAIL misalign: got %b expected %b", misalign, mis);
    end
    case (phase)
      0: begin
        vectors++;
        if (req_ready !== 1'b1) begin
          errors++; $display("FAIL req_ready_idle: got %b expected 1", req_ready);
        end
        vectors++;
        if (need_stall !== (r && w && !m[1] && !mis)) begin
          errors++; $display("FAIL need_stall_idle: got %b expected %b", need_stall, r && w && !m[1] && !mis);
        end
        vectors++;
        if (ram_wen !== (r && w && m[1] && !mis)) begin
          errors++; $display("FAIL ram_wen_idle: got %b expected %b", ram_wen, r && w && m[1] && !mis);
        end
        if (r) begin
          vectors++;
          if (ram_addr !== a[11:2]) begin
            errors++; $display("FAIL ram_addr_idle: got %h expected %h", ram_addr, a[11:2]);
          end
          if (!w) begin
            exp_ld_vld = 1'b1;
            exp_ld_dat = mis ? 32'h0 : ref_load(a[11:0], m, u);
          end else if (!mis) begin
            if (m[1]) begin
              vectors++;
              if (ram_wdata !== d) begin
                errors++; $display("FAIL ram_wdata_sw: got %h expected %h", ram_wdata, d);
              end
              ref_store(a[11:0], m, d);
            end else begin
              phase = 1; pend_a = a; pend_m = m; pend_d = d;
            end
          end
        end
      end
      1: begin
        ref_store(pend_a[11:0], pend_m, pend_d);
        ew = ref_word(pend_a[11:0]);
        vectors++;
        if (req_ready !== 1'b0 || need_stall !== 1'b0 || ram_wen !== 1'b1) begin
          errors++; $display("FAIL rmw_rd_ctl: got rdy=%b stall=%b wen=%b expected 0 0 1", req_ready, need_stall, ram_wen);
        end
        vectors++;
        if (ram_addr !== pend_a[11:2] || ram_wdata !== ew) begin
          errors++; $display("FAIL rmw_rd_data: got %h/%h expected %h/%h", ram_addr, ram_wdata, pend_a[11:2], ew);
        end
        phase = 2;
      end
      default: begin
        vectors++;
        if (req_ready !== 1'b0 || need_stall !== 1'b0 || ram_wen !== 1'b0) begin
          errors++; $display("FAIL rmw_wr_ctl: got rdy=%b stall=%b wen=%b expected 0 0 0", req_ready, need_stall, ram_wen);
        end
        phase = 0;
      end
    endcase
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_reset;
    rst = 1'b1; req = 1'b1; req_wen = 1'b1; req_mask = 2'b10; req_unsigned = 1'b0;
    req_addr = 32'h10; req_wdata = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    #1;
    vectors++;
    if (ram_wen !== 1'b0 || need_stall !== 1'b0) begin
      errors++; $display("FAIL reset_gate: got wen=%b stall=%b expected 0 0", ram_wen, need_stall);
    end
    @(negedge clk);
    rst = 1'b0; req = 1'b0;
    #1;
    vectors++;
    if ({req_ready, need_stall, ram_wen, ld_valid, misalign} !== 5'b10000) begin
      errors++; $display("FAIL reset_ctl: got %b expected 10000", {req_ready, need_stall, ram_wen, ld_valid, misalign});
    end
    vectors++;
    if (ld_data !== 32'h0 || ram_addr !== 10'h0 || ram_wdata !== 32'h0) begin
      errors++; $display("FAIL reset_data: got %h/%h/%h expected 0/0/0", ld_data, ram_addr, ram_wdata);
    end
  endtask

  task automatic test_word;
    step(1'b1, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    step(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    step(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    vectors++;
    if (ld_valid !== 1'b1 || ld_data !== 32'hDEADBEEF) begin
      errors++; $display("FAIL lw_const: got %b/%h expected 1/deadbeef", ld_valid, ld_data);
    end
  endtask

  task automatic test_sb;
    step(1'b1, 1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344);
    step(1'b1, 1'b1, 2'b00, 1'b0, 32'h21, 32'h000000AA);
    step(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    vectors++;
    if (ram_wen !== 1'b1 || ram_wdata !== 32'h1122AA44) begin
      errors++; $display("FAIL sb_merge: got %b/%h expected 1/1122aa44", ram_wen, ram_wdata);
    end
    idle(2);
    vectors++;
    if (mem[8] !== 32'h1122AA44) begin
      errors++; $display("FAIL sb_ram: got %h expected 1122aa44", mem[8]);
    end
  endtask

  task automatic test_sh;
    step(1'b1, 1'b1, 2'b10, 1'b0, 32'h20, 32'h11223344);
    step(1'b1, 1'b1, 2'b01, 1'b0, 32'h22, 32'h0000BEEF);
    idle(2);
    vectors++;
    if (mem[8] !== 32'hBEEF3344) begin
      errors++; $display("FAIL sh_ram: got %h expected beef3344", mem[8]);
    end
    step(1'b1, 1'b0, 2'b01, 1'b1, 32'h22, 32'h0);
    step(1'b1, 1'b0, 2'b01, 1'b0, 32'h22, 32'h0);
    vectors++;
    if (ld_data !== 32'h0000BEEF) begin
      errors++; $display("FAIL lhu_const: got %h expected 0000beef", ld_data);
    end
    idle(1);
    vectors++;
    if (ld_data !== 32'hFFFFBEEF) begin
      errors++; $display("FAIL lh_const: got %h expected ffffbeef", ld_data);
    end
  endtask

  task automatic test_lb;
    step(1'b1, 1'b1, 2'b10, 1'b0, 32'h0, 32'h80000000);
    step(1'b1, 1'b0, 2'b00, 1'b0, 32'h3, 32'h0);
    step(1'b1, 1'b0, 2'b00, 1'b1, 32'h3, 32'h0);
    vectors++;
    if (ld_data !== 32'hFFFFFF80) begin
      errors++; $display("FAIL lb_const: got %h expected ffffff80", ld_data);
    end
    idle(1);
    vectors++;
    if (ld_data !== 32'h00000080) begin
      errors++; $display("FAIL lbu_const: got %h expected 00000080", ld_data);
    end
  endtask

  task automatic test_rmw_reset;
    step(1'b1, 1'b1, 2'b10, 1'b0, 32'h40, 32'h55667788);
    step(1'b1, 1'b1, 2'b00, 1'b0, 32'h41, 32'h00000099);
    @(negedge clk);
    rst = 1'b1; req = 1'b0;
    #1;
    vectors++;
    if (ram_wen !== 1'b0) begin
      errors++; $display("FAIL rst_abort_wen: got %b expected 0", ram_wen);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++;
    if (req_ready !== 1'b1 || need_stall !== 1'b0 || ld_valid !== 1'b0) begin
      errors++; $display("FAIL rst_abort_state: got rdy=%b stall=%b vld=%b expected 1 0 0", req_ready, need_stall, ld_valid);
    end
    vectors++;
    if (mem[16] !== 32'h55667788) begin
      errors++; $display("FAIL rst_abort_ram: got %h expected 55667788", mem[16]);
    end
    phase = 0;
    exp_ld_vld = 1'b0;
    step(1'b1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0);
    idle(1);
  endtask

  task automatic test_misalign;
    step(1'b1, 1'b1, 2'b10, 1'b0, 32'h10, 32'h12345678);
    step(1'b1, 1'b1, 2'b10, 1'b0, 32'h13, 32'hCAFEF00D);
    idle(1);
    vectors++;
`ifdef DMEM_MISALIGN_EN
    if (mem[4] !== 32'h12345678) begin
      errors++; $display("FAIL misalign_ram: got %h expected 12345678", mem[4]);
    end
`else
    if (mem[4] !== 32'hCAFEF00D) begin
      errors++; $display("FAIL forced_align_ram: got %h expected cafef00d", mem[4]);
    end
`endif
  endtask

  task automatic test_ignored;
    step(1'b1, 1'b1, 2'b00, 1'b0, 32'h30, 32'h5A);
    step(1'b1, 1'b0, 2'b10, 1'b0, 32'h30, 32'h0);
    step(1'b1, 1'b1, 2'b10, 1'b0, 32'h34, 32'h77777777);
    idle(1);
    vectors++;
    if (ld_valid !== 1'b0) begin
      errors++; $display("FAIL ignored_req: got ld_valid=%b expected 0", ld_valid);
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 16; i++)
      step(1'b1, 1'b0, 2'($urandom_range(0, 3)), 1'($urandom), $urandom, 32'h0);
    idle(1);
  endtask

  task automatic test_random;
    for (int i = 0; i < 500; i++)
      step(1'($urandom_range(0, 7) != 0), 1'($urandom), 2'($urandom_range(0, 3)),
           1'($urandom), $urandom, $urandom);
    idle(3);
  endtask

  task automatic test_final_ram;
    for (int i = 0; i < 1024; i++) begin
      vectors++;
      if (mem[i] !== ref_word(12'(i * 4))) begin
        errors++; $display("FAIL ram_word[%0d]: got %h expected %h", i, mem[i], ref_word(12'(i * 4)));
      end
    end
  endtask

  initial begin
    logic [31:0] w;
    for (int i = 0; i < 1024; i++) begin
      w = $urandom;
      mem[i] = w;
      for (int k = 0; k < 4; k++) ref_b[4 * i + k] = w[8*k +: 8];
    end
    test_reset();
    test_word();
    test_sb();
    test_sh();
    test_lb();
    test_rmw_reset();
    test_misalign();
    test_ignored();
    test_back_to_back();
    test_random();
    test_final_ram();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
